// File: rtl/ov7725_pwr_seq.sv
// OV7725 power-up sequencer: power-down hold, reset hold, settle delay,
// SCCB init handshake with timeout, then run/fail until restarted.
module ov7725_pwr_seq #(
  parameter int unsigned PWDN_CYCLES   = 1000,
  parameter int unsigned RST_CYCLES    = 1000,
  parameter int unsigned SETTLE_CYCLES = 50000,
  parameter int unsigned INIT_TIMEOUT  = 1000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RESTART,
  input  logic INIT_DONE,
  output logic CAM_PWDN,
  output logic CAM_RESETN,
  output logic INIT_START,
  output logic READY,
  output logic FAIL
);

  // Legal parameter range is 1..2^20-1 so every terminal count fits the counter.
  localparam int unsigned CNT_W = 20;

  localparam logic [CNT_W-1:0] PWDN_LAST    = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_PWDN   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_INIT   = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cam_pwdn_q;
  logic               cam_resetn_q;
  logic               init_start_q;
  logic               ready_q;
  logic               fail_q;

  // Sequencer: state, shared cycle counter and registered pin/status outputs.
  // Outputs are updated together with the state so they always reflect it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_PWDN;
      cnt_q        <= '0;
      cam_pwdn_q   <= 1'b1;
      cam_resetn_q <= 1'b0;
      init_start_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      init_start_q <= 1'b0;
      case (state_q)
        S_PWDN: begin
          if (cnt_q == PWDN_LAST) begin
            state_q    <= S_RST;
            cnt_q      <= '0;
            cam_pwdn_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q      <= S_SETTLE;
            cnt_q        <= '0;
            cam_resetn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            init_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_INIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (INIT_DONE) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q <= S_FAIL;
            cnt_q   <= '0;
            fail_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN, S_FAIL: begin
          // Counter is parked here; only a restart request leaves these states.
          if (RESTART) begin
            state_q      <= S_PWDN;
            cnt_q        <= '0;
            cam_pwdn_q   <= 1'b1;
            cam_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_PWDN;
          cnt_q        <= '0;
          cam_pwdn_q   <= 1'b1;
          cam_resetn_q <= 1'b0;
          ready_q      <= 1'b0;
          fail_q       <= 1'b0;
        end
      endcase
    end
  end

  assign CAM_PWDN   = cam_pwdn_q;
  assign CAM_RESETN = cam_resetn_q;
  assign INIT_START = init_start_q;
  assign READY      = ready_q;
  assign FAIL       = fail_q;

endmodule

// File: doc/ov7725_pwr_seq.md
OV7725_PWR_SEQ -- requirements
Module: ov7725_pwr_seq

Interface
REQ-001 SHALL have parameter PWDN_CYCLES, default 1000: cycles CAM_PWDN is held high after reset release.
REQ-002 SHALL have parameter RST_CYCLES, default 1000: cycles CAM_RESETN is held low after CAM_PWDN falls.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 50000: cycles from CAM_RESETN rise to INIT_START.
REQ-004 SHALL have parameter INIT_TIMEOUT, default 1000000: maximum cycles spent waiting for INIT_DONE.
REQ-005 SHALL have port CLK, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1: reset, synchronous and active-high; it is the output of the upstream reset generator.
REQ-007 SHALL have port RESTART, input, 1: single-cycle request to rerun the power sequence.
REQ-008 SHALL have port INIT_DONE, input, 1: pulse from the SCCB register loader when configuration completes.
REQ-009 SHALL have port CAM_PWDN, output, 1: OV7725 power-down pin, active-high.
REQ-010 SHALL have port CAM_RESETN, output, 1: OV7725 reset pin, active-low.
REQ-011 SHALL have port INIT_START, output, 1: one-cycle pulse that starts the SCCB register loader.
REQ-012 SHALL have port READY, output, 1: camera configured; downstream capture/LCD path may run.
REQ-013 SHALL have port FAIL, output, 1: INIT_DONE timeout occurred.

Function
REQ-014 SHALL use states S_PWDN, S_RST, S_SETTLE, S_INIT, S_RUN and S_FAIL, with a single shared 20-bit cycle counter.
REQ-015 SHALL clear the counter on every state transition.
REQ-016 SHALL register all outputs, with no combinational path from any input to any output.
REQ-017 In S_PWDN, SHALL drive CAM_PWDN=1 and CAM_RESETN=0; on counter==PWDN_CYCLES-1, SHALL move to S_RST.
REQ-018 In S_RST, SHALL drive CAM_PWDN=0 and CAM_RESETN=0; on counter==RST_CYCLES-1, SHALL move to S_SETTLE.
REQ-019 In S_SETTLE, SHALL drive CAM_PWDN=0 and CAM_RESETN=1; on counter==SETTLE_CYCLES-1, SHALL move to S_INIT.
REQ-020 SHALL assert INIT_START for exactly the first cycle in S_INIT, once per S_INIT entry.
REQ-021 In S_INIT, on INIT_DONE=1, SHALL move to S_RUN; otherwise, on counter==INIT_TIMEOUT-1, SHALL move to S_FAIL.
REQ-022 If INIT_DONE and timeout coincide in the same cycle, SHALL give INIT_DONE priority, moving to S_RUN.
REQ-023 SHALL assert READY=1 only while in S_RUN, and FAIL=1 only while in S_FAIL.
REQ-024 On RESTART=1 in S_RUN or S_FAIL, SHALL move to S_PWDN, dropping READY/FAIL and raising CAM_PWDN on the next edge.
REQ-025 SHALL ignore RESTART in S_PWDN, S_RST, S_SETTLE and S_INIT, with no sequence extension.
REQ-026 SHALL ignore INIT_DONE outside S_INIT, including a stale pulse in S_RUN.
REQ-027 SHALL stop the counter in S_RUN and S_FAIL, with no wrap-around.
REQ-028 Each parameter SHALL be in the range 1..2^20-1; any other value is illegal.

Reset
REQ-029 While RESET=1 at a rising CLK edge, SHALL set state=S_PWDN, counter=0, CAM_PWDN=1, CAM_RESETN=0, INIT_START=0, READY=0 and FAIL=0.
REQ-030 Reset asserted mid-sequence or in S_RUN SHALL abort immediately and restart the full sequence after release.
REQ-031 With edge 1 as the first edge with RESET=0, CAM_PWDN SHALL fall after edge PWDN_CYCLES.
REQ-032 CAM_RESETN SHALL rise after edge PWDN_CYCLES+RST_CYCLES.
REQ-033 INIT_START SHALL be high in the cycle after edge P+R+S, where P=PWDN_CYCLES, R=RST_CYCLES and S=SETTLE_CYCLES.

Verification
REQ-034 A bench with P=4, R=3, S=5, T=10 (T=INIT_TIMEOUT) and clean reset release SHALL see CAM_PWDN fall after edge 4, CAM_RESETN rise after edge 7, a single INIT_START after edge 12, and READY=0 throughout.
REQ-035 With INIT_DONE pulsed 3 cycles after INIT_START, the bench SHALL see READY=1 on the next edge and READY held while idle.
REQ-036 With INIT_DONE never pulsed, the bench SHALL see FAIL=1 exactly 10 cycles after INIT_START, with READY=0 and CAM_RESETN=1 held.
REQ-037 With INIT_DONE pulsed on the timeout cycle, the bench SHALL see READY=1 and FAIL=0.
REQ-038 With RESTART in S_RUN, the bench SHALL see READY=0 and CAM_PWDN=1 next edge, then the full sequence repeat with identical timing; RESTART during S_RST SHALL leave timing unchanged.
REQ-039 With RESET pulsed 1 cycle during S_SETTLE, the bench SHALL see all outputs at reset values next edge and the sequence restart from edge 1.
